tbuf_bus_owner_ctrl: RTL and testbench

- Controls ownership of a shared tri-state bus driven by TBUF cells whose enables are active-low (EN = ~enable).
- Arbitrates round-robin among NUM_DRV requesters and drives exactly one active-low enable at a time.
- Inserts a turnaround gap between owners so that no two drivers ever overlap.
- Acts as the bus's receiving end: samples the resolved bus and presents each beat with its source index to downstream logic.

---
 rtl/tbuf_bus_pkg.sv | 33 +++
 rtl/rr_pick_first.sv | 47 ++++
 rtl/tbuf_bus_owner_ctrl.sv | 160 ++++++++++++++++
 tb/tb_tbuf_bus_owner_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/tbuf_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tbuf_bus_pkg
//  Description : Shared types and helpers for the tri-state bus owner
//                controller: owner FSM state encoding, index-width helper and
//                the all-deasserted (all 1s) active-low enable constant.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package tbuf_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      TURN  = 2'd2
   } owner_state_e;

   // Largest supported driver count; enable constants are sized to this and
   // sliced down by the user.
   localparam int MAX_DRV = 16;

   typedef logic [MAX_DRV-1:0] enable_vec_t;

   // Active-low enables: all ones means no TBUF is driving.
   localparam enable_vec_t ENABLE_OFF = '1;

   // Width of a driver index; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : tbuf_bus_pkg
`default_nettype wire

// File: rtl/rr_pick_first.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick_first
//  Description : Combinational round-robin first-set finder. Searches vec_i
//                upward starting at ptr_i, wrapping modulo NUM_DRV, and
//                returns the first set position.
//  Ports       : vec_i   - request vector (NUM_DRV bits)
//                ptr_i   - search start index
//                found_o - at least one bit of vec_i is set
//                idx_o   - index of the first set bit (0 when none)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick_first
   import tbuf_bus_pkg::*;
#(
   parameter int NUM_DRV = 5
) (
   input  logic [NUM_DRV-1:0]              vec_i,
   input  logic [idx_width(NUM_DRV)-1:0]   ptr_i,
   output logic                            found_o,
   output logic [idx_width(NUM_DRV)-1:0]   idx_o
);

   localparam int IDX_W = idx_width(NUM_DRV);

   // One extra bit so ptr + offset cannot overflow before the wrap.
   logic [IDX_W:0] cand;

   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int i = 0; i < NUM_DRV; i++) begin
         cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
         // ptr < NUM_DRV and i < NUM_DRV, so one subtraction wraps fully.
         if (cand >= (IDX_W+1)'(NUM_DRV)) begin
            cand = cand - (IDX_W+1)'(NUM_DRV);
         end
         if (!found_o && vec_i[cand[IDX_W-1:0]]) begin
            found_o = 1'b1;
            idx_o   = cand[IDX_W-1:0];
         end
      end
   end

endmodule : rr_pick_first
`default_nettype wire

// File: rtl/tbuf_bus_owner_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tbuf_bus_owner_ctrl
//  Description : Ownership controller for a shared tri-state bus built from
//                TBUF cells with active-low enables. Round-robin arbitration
//                among NUM_DRV requesters, a TURN_CYC all-released gap
//                between owners, and a receive side that captures each beat
//                from the resolved bus with the index of its driver.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-high reset
//                req_i      - per-driver level request
//                done_i     - per-driver release pulse (owner bit only)
//                bus_in_i   - resolved shared bus value
//                enable_n_o - registered active-low TBUF enables
//                grant_o    - one-hot owner, equal to ~enable_n_o
//                rx_valid_o - captured beat valid
//                rx_data_o  - captured bus value
//                rx_src_o   - index of the driver of rx_data_o
//                bus_idle_o - high while no owner and no turnaround
//  Revision    : 1.0 - initial release
// ============================================================================
module tbuf_bus_owner_ctrl
   import tbuf_bus_pkg::*;
#(
   parameter int NUM_DRV  = 5,
   parameter int DATA_W   = 5,
   parameter int MAX_HOLD = 4,
   parameter int TURN_CYC = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_DRV-1:0]            req_i,
   input  logic [NUM_DRV-1:0]            done_i,
   input  logic [DATA_W-1:0]             bus_in_i,
   output logic [NUM_DRV-1:0]            enable_n_o,
   output logic [NUM_DRV-1:0]            grant_o,
   output logic                          rx_valid_o,
   output logic [DATA_W-1:0]             rx_data_o,
   output logic [idx_width(NUM_DRV)-1:0] rx_src_o,
   output logic                          bus_idle_o
);

   localparam int IDX_W  = idx_width(NUM_DRV);
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam int TURN_W = 3;

   localparam logic [NUM_DRV-1:0] EN_OFF   = ENABLE_OFF[NUM_DRV-1:0];
   localparam logic [NUM_DRV-1:0] ONE_HOT0 = {{(NUM_DRV-1){1'b0}}, 1'b1};

   owner_state_e        state_q;
   logic [IDX_W-1:0]    owner_q;
   logic [IDX_W-1:0]    ptr_q;
   logic [HOLD_W-1:0]   hold_q;
   logic [TURN_W-1:0]   turn_q;
   logic [NUM_DRV-1:0]  enable_n_q;
   logic                rx_valid_q;
   logic [DATA_W-1:0]   rx_data_q;
   logic [IDX_W-1:0]    rx_src_q;
   logic                bus_idle_q;

   logic                pick_found;
   logic [IDX_W-1:0]    pick_idx;
   logic [NUM_DRV-1:0]  pick_en_n;
   logic                release_now;
   logic [IDX_W-1:0]    ptr_d;

   rr_pick_first #(
      .NUM_DRV (NUM_DRV)
   ) u_pick (
      .vec_i   (req_i),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   assign pick_en_n = ~(ONE_HOT0 << pick_idx);

   // Only the current owner's done/req bits can end the grant.
   assign release_now = done_i[owner_q] || !req_i[owner_q] ||
                        (hold_q == HOLD_W'(MAX_HOLD));

   assign ptr_d = (owner_q == IDX_W'(NUM_DRV - 1)) ? '0 : owner_q + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         ptr_q      <= '0;
         hold_q     <= '0;
         turn_q     <= '0;
         enable_n_q <= EN_OFF;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
         rx_src_q   <= '0;
         bus_idle_q <= 1'b1;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  state_q    <= DRIVE;
                  owner_q    <= pick_idx;
                  enable_n_q <= pick_en_n;
                  hold_q     <= HOLD_W'(1);
                  bus_idle_q <= 1'b0;
               end
            end

            DRIVE: begin
               // hold_q == 1 marks the settle cycle: bus not yet stable.
               if (hold_q != HOLD_W'(1)) begin
                  rx_valid_q <= 1'b1;
                  rx_data_q  <= bus_in_i;
                  rx_src_q   <= owner_q;
               end
               if (hold_q != HOLD_W'(MAX_HOLD)) begin
                  hold_q <= hold_q + 1'b1;
               end
               if (release_now) begin
                  state_q    <= TURN;
                  enable_n_q <= EN_OFF;
                  turn_q     <= TURN_W'(1);
                  ptr_q      <= ptr_d;
               end
            end

            TURN: begin
               if (turn_q == TURN_W'(TURN_CYC)) begin
                  if (pick_found) begin
                     state_q    <= DRIVE;
                     owner_q    <= pick_idx;
                     enable_n_q <= pick_en_n;
                     hold_q     <= HOLD_W'(1);
                  end else begin
                     state_q    <= IDLE;
                     bus_idle_q <= 1'b1;
                  end
               end else begin
                  turn_q <= turn_q + 1'b1;
               end
            end

            default: begin
               state_q    <= IDLE;
               enable_n_q <= EN_OFF;
               bus_idle_q <= 1'b1;
            end
         endcase
      end
   end

   assign enable_n_o = enable_n_q;
   assign grant_o    = ~enable_n_q;
   assign rx_valid_o = rx_valid_q;
   assign rx_data_o  = rx_data_q;
   assign rx_src_o   = rx_src_q;
   assign bus_idle_o = bus_idle_q;

endmodule : tbuf_bus_owner_ctrl
`default_nettype wire

// File: tb/tb_tbuf_bus_owner_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tbuf_bus_owner_ctrl
//  Description : Directed self-checking bench for tbuf_bus_owner_ctrl.
//                Instance u_dut uses TURN_CYC = 1, u_dut3 uses TURN_CYC = 3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tbuf_bus_owner_ctrl;

   logic       clk;
   logic       rst, rst3;
   logic [4:0] req, done, bus_in;
   logic [4:0] req3, done3, bus_in3;
   logic [4:0] enable_n, grant, rx_data;
   logic [4:0] enable_n3, grant3, rx_data3;
   logic [2:0] rx_src, rx_src3;
   logic       rx_valid, bus_idle, rx_valid3, bus_idle3;

   int total = 0;
   int bad   = 0;

   tbuf_bus_owner_ctrl #(
      .NUM_DRV(5), .DATA_W(5), .MAX_HOLD(4), .TURN_CYC(1)
   ) u_dut (
      .clk(clk), .rst(rst), .req_i(req), .done_i(done), .bus_in_i(bus_in),
      .enable_n_o(enable_n), .grant_o(grant), .rx_valid_o(rx_valid),
      .rx_data_o(rx_data), .rx_src_o(rx_src), .bus_idle_o(bus_idle)
   );

   tbuf_bus_owner_ctrl #(
      .NUM_DRV(5), .DATA_W(5), .MAX_HOLD(4), .TURN_CYC(3)
   ) u_dut3 (
      .clk(clk), .rst(rst3), .req_i(req3), .done_i(done3), .bus_in_i(bus_in3),
      .enable_n_o(enable_n3), .grant_o(grant3), .rx_valid_o(rx_valid3),
      .rx_data_o(rx_data3), .rx_src_o(rx_src3), .bus_idle_o(bus_idle3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold reset across two edges with the given request pattern, then release.
   task automatic do_reset(input logic [4:0] r);
      rst  = 1'b1;
      req  = r;
      done = 5'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 5'b0; done = 5'b0; bus_in = 5'h15;
      rst3 = 1'b1; req3 = 5'b0; done3 = 5'b0; bus_in3 = 5'h0A;

      // ---- reset with req[3] held, then first grant and owner-3 tenure ----
      do_reset(5'b01000);
      chk("rst_en_n", 32'(enable_n), 32'h1F);
      chk("rst_idle", 32'(bus_idle), 32'h1);
      chk("rst_rxv",  32'(rx_valid), 32'h0);
      chk("rst_grant", 32'(grant), 32'h0);
      tick(); // E1
      chk("grant3_en_n", 32'(enable_n), 32'h17);
      chk("grant3_grant", 32'(grant), 32'h08);
      chk("grant3_idle", 32'(bus_idle), 32'h0);
      tick(); // E2: settle cycle consumed
      chk("settle_rxv", 32'(rx_valid), 32'h0);
      for (int k = 0; k < 3; k++) begin // E3..E5: three beats
         tick();
         chk("beat_rxv",  32'(rx_valid), 32'h1);
         chk("beat_data", 32'(rx_data), 32'h15);
         chk("beat_src",  32'(rx_src), 32'h3);
         chk("beat_en_n", 32'(enable_n), (k == 2) ? 32'h1F : 32'h17);
      end
      tick(); // E6: one-cycle gap over, owner 3 again
      chk("regrant_en_n", 32'(enable_n), 32'h17);
      chk("regrant_rxv",  32'(rx_valid), 32'h0);

      // ---- all requesting: rotation 0,1,2,3,4,0 with 1-cycle gaps ----
      do_reset(5'b11111);
      for (int k = 1; k <= 30; k++) begin
         logic [4:0] e;
         tick();
         e = 5'b11111;
         if (((k - 1) % 5) < 4) e[((k - 1) / 5) % 5] = 1'b0;
         chk("rot_en_n", 32'(enable_n), 32'(e));
         chk("rot_onehot", 32'($countones(~enable_n) <= 1), 32'h1);
      end

      // ---- done from owner with simultaneous req[4] and stray done[2] ----
      do_reset(5'b00001);
      tick(); // E1: owner 0 first DRIVE cycle
      chk("own0_en_n", 32'(enable_n), 32'h1E);
      tick(); // E2: owner 0 second DRIVE cycle
      done = 5'b00101;
      req  = 5'b10001;
      tick(); // E3: released
      done = 5'b00000;
      chk("done_rel_en_n", 32'(enable_n), 32'h1F);
      chk("done_rel_rxv",  32'(rx_valid), 32'h1);
      chk("done_rel_src",  32'(rx_src), 32'h0);
      tick(); // E4: owner 4 wins from pointer 1
      chk("own4_en_n", 32'(enable_n), 32'h0F);
      chk("own4_grant", 32'(grant), 32'h10);
      req = 5'b00000;
      tick(); // E5: req dropped -> TURN
      chk("drop_en_n", 32'(enable_n), 32'h1F);
      chk("drop_rxv",  32'(rx_valid), 32'h0);
      chk("drop_idle", 32'(bus_idle), 32'h0);
      tick(); // E6: nothing pending -> IDLE
      chk("idle_back", 32'(bus_idle), 32'h1);
      chk("idle_en_n", 32'(enable_n), 32'h1F);

      // ---- asynchronous reset during owner 2's DRIVE ----
      do_reset(5'b00100);
      tick(); // owner 2
      chk("own2_en_n", 32'(enable_n), 32'h1B);
      tick();
      tick(); // first beat captured
      chk("own2_rxv", 32'(rx_valid), 32'h1);
      #2;
      rst = 1'b1;
      #1; // well before the next rising edge
      chk("async_en_n",  32'(enable_n), 32'h1F);
      chk("async_rxv",   32'(rx_valid), 32'h0);
      chk("async_grant", 32'(grant), 32'h0);
      chk("async_idle",  32'(bus_idle), 32'h1);
      tick();
      rst = 1'b0;

      // ---- TURN_CYC = 3 instance with req[1] pending ----
      req3 = 5'b00010;
      tick();
      rst3 = 1'b0;
      tick(); // E1
      chk("t3_grant_en_n", 32'(enable_n3), 32'h1D);
      for (int k = 2; k <= 8; k++) begin
         tick();
         // E2..E4 drive, E5..E7 all high, E8 re-granted
         chk("t3_en_n", 32'(enable_n3), (k >= 5 && k <= 7) ? 32'h1F : 32'h1D);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_tbuf_bus_owner_ctrl
`default_nettype wire
